// File: rtl/m_div_ctrl_pkg.sv
// ============================================================================
// Module      : m_div_ctrl_pkg
// Description : Shared encodings, op codes and FSM states for the divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package m_div_ctrl_pkg;

  localparam int MUX_R_W = 2;
  localparam logic [MUX_R_W-1:0] MUX_R_KEEP     = 2'd0;
  localparam logic [MUX_R_W-1:0] MUX_R_A        = 2'd1;
  localparam logic [MUX_R_W-1:0] MUX_R_A_NEG    = 2'd2;
  localparam logic [MUX_R_W-1:0] MUX_R_SUB_KEEP = 2'd3;

  localparam int MUX_D_W = 2;
  localparam logic [MUX_D_W-1:0] MUX_D_KEEP  = 2'd0;
  localparam logic [MUX_D_W-1:0] MUX_D_B     = 2'd1;
  localparam logic [MUX_D_W-1:0] MUX_D_B_NEG = 2'd2;
  localparam logic [MUX_D_W-1:0] MUX_D_SHR   = 2'd3;

  localparam int MUX_Z_W = 2;
  localparam logic [MUX_Z_W-1:0] MUX_Z_KEEP    = 2'd0;
  localparam logic [MUX_Z_W-1:0] MUX_Z_ZERO    = 2'd1;
  localparam logic [MUX_Z_W-1:0] MUX_Z_SHL_ADD = 2'd2;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam int SPECIAL_W = 2;
  localparam logic [SPECIAL_W-1:0] SPECIAL_NONE = 2'd0;
  localparam logic [SPECIAL_W-1:0] SPECIAL_DIV0 = 2'd1;
  localparam logic [SPECIAL_W-1:0] SPECIAL_OVF  = 2'd2;

  localparam int CNT_W      = 6;
  localparam int ITER_COUNT = 32;
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Unlisted funct3 values fall through to DIVU: unsigned, quotient.
  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_div_ctrl.sv
// ============================================================================
// Module      : m_div_ctrl
// Description : Control FSM for a 32-cycle restoring divider datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_div_ctrl
  import m_div_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [31:0]          rs1,
  input  logic [31:0]          rs2,
  input  logic                 flush,
  output logic [MUX_R_W-1:0]   mux_R,
  output logic [MUX_D_W-1:0]   mux_D,
  output logic [MUX_Z_W-1:0]   mux_Z,
  output logic                 busy,
  output logic                 done,
  output logic                 sel_rem,
  output logic                 result_neg,
  output logic [SPECIAL_W-1:0] special
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   neg_a_q, neg_a_d;
  logic                   neg_b_q, neg_b_d;
  logic                   done_q, done_d;
  logic                   sel_rem_q, sel_rem_d;
  logic                   result_neg_q, result_neg_d;
  logic [SPECIAL_W-1:0]   special_q, special_d;

  logic                   w_signed;
  logic                   w_div0;
  logic                   w_ovf;
  logic [SPECIAL_W-1:0]   w_special;

  assign w_signed  = is_signed_op(funct3);
  assign w_div0    = (rs2 == 32'h0000_0000);
  assign w_ovf     = w_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign w_special = w_div0 ? SPECIAL_DIV0 : (w_ovf ? SPECIAL_OVF : SPECIAL_NONE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    neg_a_d      = neg_a_q;
    neg_b_d      = neg_b_q;
    sel_rem_d    = sel_rem_q;
    result_neg_d = result_neg_q;
    special_d    = special_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          neg_a_d   = w_signed && rs1[31];
          neg_b_d   = w_signed && rs2[31];
          sel_rem_d = is_rem_op(funct3);
          special_d = w_special;
          // Remainder takes the dividend's sign; quotient takes the XOR.
          if (w_special != SPECIAL_NONE)
            result_neg_d = 1'b0;
          else if (is_rem_op(funct3))
            result_neg_d = w_signed && rs1[31];
          else
            result_neg_d = w_signed && (rs1[31] ^ rs2[31]);
          state_d = (w_special != SPECIAL_NONE) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_LAST)
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush && (state_q != ST_IDLE))
      state_d = ST_IDLE;

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      neg_a_q      <= 1'b0;
      neg_b_q      <= 1'b0;
      done_q       <= 1'b0;
      sel_rem_q    <= 1'b0;
      result_neg_q <= 1'b0;
      special_q    <= SPECIAL_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      neg_a_q      <= neg_a_d;
      neg_b_q      <= neg_b_d;
      done_q       <= done_d;
      sel_rem_q    <= sel_rem_d;
      result_neg_q <= result_neg_d;
      special_q    <= special_d;
    end
  end

  always_comb begin
    mux_R = MUX_R_KEEP;
    mux_D = MUX_D_KEEP;
    mux_Z = MUX_Z_KEEP;
    case (state_q)
      ST_LOAD: begin
        mux_R = neg_a_q ? MUX_R_A_NEG : MUX_R_A;
        mux_D = neg_b_q ? MUX_D_B_NEG : MUX_D_B;
        mux_Z = MUX_Z_ZERO;
      end
      ST_ITER: begin
        mux_R = MUX_R_SUB_KEEP;
        mux_D = MUX_D_SHR;
        mux_Z = MUX_Z_SHL_ADD;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign sel_rem    = sel_rem_q;
  assign result_neg = result_neg_q;
  assign special    = special_q;

endmodule

`default_nettype wire

// File: tb/tb_m_div_ctrl.sv
// ============================================================================
// Module      : tb_m_div_ctrl
// Description : Scoreboard bench for the divider control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_div_ctrl;
  import m_div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic [1:0]  mux_R, mux_D, mux_Z;
  logic        busy, done, sel_rem, result_neg;
  logic [1:0]  special;

  typedef struct packed {
    logic       sel_rem;
    logic       result_neg;
    logic [1:0] special;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  m_div_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .flush      (flush),
    .mux_R      (mux_R),
    .mux_D      (mux_D),
    .mux_Z      (mux_Z),
    .busy       (busy),
    .done       (done),
    .sel_rem    (sel_rem),
    .result_neg (result_neg),
    .special    (special)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin : sb_mon
    exp_t e;
    if (done === 1'b1 && reset === 1'b0) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_sel_rem", {31'b0, sel_rem}, {31'b0, e.sel_rem});
        check("sb_result_neg", {31'b0, result_neg}, {31'b0, e.result_neg});
        check("sb_special", {30'b0, special}, {30'b0, e.special});
      end
    end
  end

  task automatic check_keep(input string tag);
    check({tag, "_muxR"}, {30'b0, mux_R}, {30'b0, MUX_R_KEEP});
    check({tag, "_muxD"}, {30'b0, mux_D}, {30'b0, MUX_D_KEEP});
    check({tag, "_muxZ"}, {30'b0, mux_Z}, {30'b0, MUX_Z_KEEP});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_sel_rem"}, {31'b0, sel_rem}, 32'd0);
    check({tag, "_result_neg"}, {31'b0, result_neg}, 32'd0);
    check({tag, "_special"}, {30'b0, special}, {30'b0, SPECIAL_NONE});
    check_keep(tag);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int reset_at, input bit busy_starts);
    logic       sgn, rem, div0, ovf;
    logic [1:0] sp;
    exp_t       e;
    logic [1:0] exp_r, exp_d;
    sgn  = (f3 == 3'b100) || (f3 == 3'b110);
    rem  = (f3 == 3'b110) || (f3 == 3'b111);
    div0 = (b == 32'd0);
    ovf  = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    sp   = div0 ? 2'd1 : (ovf ? 2'd2 : 2'd0);
    e.sel_rem    = rem;
    e.special    = sp;
    e.result_neg = (sp != 2'd0) ? 1'b0 : (rem ? (sgn & a[31]) : (sgn & (a[31] ^ b[31])));
    exp_r = (sgn && a[31]) ? 2'd2 : 2'd1;
    exp_d = (sgn && b[31]) ? 2'd2 : 2'd1;
    if (flush_at < 0 && reset_at < 0) sb_q.push_back(e);

    @(negedge clk);
    start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    if (sp != 2'd0) begin
      check("special_done_lat", {31'b0, done}, 32'd1);
      check("special_busy", {31'b0, busy}, 32'd1);
      check_keep("special");
      @(negedge clk);
      check("special_idle_busy", {31'b0, busy}, 32'd0);
      return;
    end
    check("load_muxR", {30'b0, mux_R}, {30'b0, exp_r});
    check("load_muxD", {30'b0, mux_D}, {30'b0, exp_d});
    check("load_muxZ", {30'b0, mux_Z}, 32'd1);
    check("load_done", {31'b0, done}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (busy_starts) begin
        start = (i >= 5 && i <= 7);
        funct3 = 3'b100; rs1 = 32'h8000_0000; rs2 = 32'hFFFF_FFFF;
      end
      check("iter_muxR", {30'b0, mux_R}, 32'd3);
      check("iter_muxD", {30'b0, mux_D}, 32'd3);
      check("iter_muxZ", {30'b0, mux_Z}, 32'd2);
      check("iter_done", {31'b0, done}, 32'd0);
      if (i == flush_at) begin
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        check_keep("flush");
        @(negedge clk);
        check("flush_done2", {31'b0, done}, 32'd0);
        return;
      end
      if (i == reset_at) begin
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_done", {31'b0, done}, 32'd0);
        return;
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("done_lat", {31'b0, done}, 32'd1);
    check_keep("done");
    @(negedge clk);
    check("post_busy", {31'b0, busy}, 32'd0);
    check("post_done", {31'b0, done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    run_op(3'b101, 32'd100, 32'd7, -1, -1, 1'b0);
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7, -1, -1, 1'b0);
    run_op(3'b110, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, -1, 1'b0);
    run_op(3'b111, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, -1, 1'b0);
    run_op(3'b100, 32'd5, 32'd0, -1, -1, 1'b0);
    run_op(3'b111, 32'd5, 32'd0, -1, -1, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
    run_op(3'b000, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, -1, 1'b0);
    run_op(3'b101, 32'd1000, 32'd3, 10, -1, 1'b0);
    run_op(3'b100, 32'd50, 32'hFFFF_FFFB, -1, -1, 1'b0);
    run_op(3'b101, 32'd77, 32'd5, -1, -1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("no_queued_busy", {31'b0, busy}, 32'd0);
    end

    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b100; rs1 = 32'd9; rs2 = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'b0, busy}, 32'd0);
    check("flush_start_done", {31'b0, done}, 32'd0);

    run_op(3'b110, 32'd12345, 32'd17, -1, 20, 1'b0);
    run_op(3'b110, 32'hFFFF_FF9C, 32'd7, -1, -1, 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
